cmult_rr_scheduler: RTL and testbench

- Shares one complex-multiplier datapath (18-bit signed I/Q operands a and b, 18-bit signed I/Q result, fixed pipeline latency) among NUM_REQ requesters.
- Round-robin arbitration, one issue per clock, valid/ready on both the request and result sides.
- Each requester has at most one transaction in flight, so results never collide and are routed back by tag.
- Sits between the requesting DSP blocks and the multiplier instance (`main`).

---
 rtl/cmult_rr_scheduler.sv | 146 ++++++++++++++
 tb/tb_cmult_rr_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmult_rr_scheduler.sv
// Round-robin scheduler sharing one complex-multiplier pipeline among
// NUM_REQ requesters. Each requester has at most one transaction in flight;
// results are routed back by a tag that travels alongside the multiplier.
module cmult_rr_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int DW       = 18,
    parameter int MULT_LAT = 3,
    parameter int TAG_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*DW-1:0] req_a_i_i,
    input  logic [NUM_REQ*DW-1:0] req_a_q_i,
    input  logic [NUM_REQ*DW-1:0] req_b_i_i,
    input  logic [NUM_REQ*DW-1:0] req_b_q_i,
    output logic                  mult_valid_o,
    output logic [DW-1:0]         mult_a_i_o,
    output logic [DW-1:0]         mult_a_q_o,
    output logic [DW-1:0]         mult_b_i_o,
    output logic [DW-1:0]         mult_b_q_o,
    input  logic [DW-1:0]         mult_res_i_i,
    input  logic [DW-1:0]         mult_res_q_i,
    output logic [NUM_REQ-1:0]    res_valid_o,
    output logic [NUM_REQ*DW-1:0] res_i_o,
    output logic [NUM_REQ*DW-1:0] res_q_o,
    input  logic [NUM_REQ-1:0]    res_ready_i,
    output logic [NUM_REQ-1:0]    busy_o
);

    logic [1:0]         rst_sync;
    logic               rst;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W-1:0]   ptr;
    logic [TAG_W-1:0]   mult_tag;
    logic [MULT_LAT-1:0] pipe_v;
    logic [TAG_W-1:0]   pipe_tag [MULT_LAT];
    logic               cap_v;
    logic [TAG_W-1:0]   cap_tag;
    int                 idx;

    // Reset asserts immediately, deasserts two clocks after srst_i falls.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) rst_sync <= 2'b11;
        else        rst_sync <= {rst_sync[0], 1'b0};
    end

    assign rst = rst_sync[1];

    // A requester competes only while it has nothing outstanding.
    assign eligible    = req_valid_i & ~busy_o & {NUM_REQ{~rst}};
    assign req_ready_o = grant;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!grant_any && eligible[idx[TAG_W-1:0]]) begin
                grant_any                = 1'b1;
                grant[idx[TAG_W-1:0]]    = 1'b1;
                grant_idx                = idx[TAG_W-1:0];
            end
        end
    end

    // Issue stage: register the granted operands and their tag.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            ptr          <= TAG_W'(NUM_REQ - 1);
            mult_valid_o <= 1'b0;
            mult_a_i_o   <= '0;
            mult_a_q_o   <= '0;
            mult_b_i_o   <= '0;
            mult_b_q_o   <= '0;
            mult_tag     <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            mult_valid_o <= grant_any;
            if (grant_any) begin
                ptr        <= grant_idx;
                mult_a_i_o <= req_a_i_i[int'(grant_idx)*DW +: DW];
                mult_a_q_o <= req_a_q_i[int'(grant_idx)*DW +: DW];
                mult_b_i_o <= req_b_i_i[int'(grant_idx)*DW +: DW];
                mult_b_q_o <= req_b_q_i[int'(grant_idx)*DW +: DW];
                mult_tag   <= grant_idx;
            end
        end
    end

    // Tag-valid shift register; clearing it drops results issued before reset.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= mult_valid_o;
            for (int k = 1; k < MULT_LAT; k++) pipe_v[k] <= pipe_v[k-1];
        end
    end

    // Tag shift register, aligned with the multiplier result.
    // NOTE: tag storage has no reset; each entry is only used when its valid bit is set.
    always_ff @(posedge clk_i) begin
        pipe_tag[0] <= mult_tag;
        for (int k = 1; k < MULT_LAT; k++) pipe_tag[k] <= pipe_tag[k-1];
    end

    assign cap_v   = pipe_v[MULT_LAT-1];
    assign cap_tag = pipe_tag[MULT_LAT-1];

    // Per-requester busy flag, result capture and result consume.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            busy_o      <= '0;
            res_valid_o <= '0;
            res_i_o     <= '0;
            res_q_o     <= '0;
        end else begin
            for (int n = 0; n < NUM_REQ; n++) begin
                if (res_valid_o[n] && res_ready_i[n]) begin
                    res_valid_o[n] <= 1'b0;
                    busy_o[n]      <= 1'b0;
                end
                if (grant[n]) busy_o[n] <= 1'b1;
                if (cap_v && int'(cap_tag) == n) begin
                    res_valid_o[n]        <= 1'b1;
                    res_i_o[n*DW +: DW]   <= mult_res_i_i;
                    res_q_o[n*DW +: DW]   <= mult_res_q_i;
                end
            end
        end
    end

    // A capture must never land on a slot whose result is still unconsumed.
    a_no_overwrite: assert property (@(posedge clk_i) disable iff (rst)
        cap_v |-> !res_valid_o[cap_tag]);

endmodule

// File: tb/tb_cmult_rr_scheduler.sv
// Self-checking bench for cmult_rr_scheduler with a behavioural multiplier
// and a transaction-level reference model of arbitration and routing.
module tb_cmult_rr_scheduler;

    localparam int NUM_REQ  = 4;
    localparam int DW       = 18;
    localparam int MULT_LAT = 3;

    logic                  clk_i = 1'b0;
    logic                  srst_i;
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ*DW-1:0] req_a_i_i, req_a_q_i, req_b_i_i, req_b_q_i;
    logic                  mult_valid_o;
    logic [DW-1:0]         mult_a_i_o, mult_a_q_o, mult_b_i_o, mult_b_q_o;
    logic [DW-1:0]         mult_res_i_i, mult_res_q_i;
    logic [NUM_REQ-1:0]    res_valid_o;
    logic [NUM_REQ*DW-1:0] res_i_o, res_q_o;
    logic [NUM_REQ-1:0]    res_ready_i;
    logic [NUM_REQ-1:0]    busy_o;

    cmult_rr_scheduler #(.NUM_REQ(NUM_REQ), .DW(DW), .MULT_LAT(MULT_LAT)) dut (
        .clk_i(clk_i), .srst_i(srst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i_i(req_a_i_i), .req_a_q_i(req_a_q_i),
        .req_b_i_i(req_b_i_i), .req_b_q_i(req_b_q_i),
        .mult_valid_o(mult_valid_o),
        .mult_a_i_o(mult_a_i_o), .mult_a_q_o(mult_a_q_o),
        .mult_b_i_o(mult_b_i_o), .mult_b_q_o(mult_b_q_o),
        .mult_res_i_i(mult_res_i_i), .mult_res_q_i(mult_res_q_i),
        .res_valid_o(res_valid_o), .res_i_o(res_i_o), .res_q_o(res_q_o),
        .res_ready_i(res_ready_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- complex multiply, truncated to DW bits ----------------
    function automatic logic [DW-1:0] cmul_i(input logic signed [DW-1:0] ai, aq, bi, bq);
        longint p;
        p = longint'(ai) * longint'(bi) - longint'(aq) * longint'(bq);
        return DW'(p);
    endfunction

    function automatic logic [DW-1:0] cmul_q(input logic signed [DW-1:0] ai, aq, bi, bq);
        longint p;
        p = longint'(ai) * longint'(bq) + longint'(aq) * longint'(bi);
        return DW'(p);
    endfunction

    // Behavioural multiplier: result of cycle-t operands appears at t+MULT_LAT.
    logic [DW-1:0] mp_i [MULT_LAT];
    logic [DW-1:0] mp_q [MULT_LAT];
    always @(posedge clk_i) begin
        mp_i[0] <= cmul_i(mult_a_i_o, mult_a_q_o, mult_b_i_o, mult_b_q_o);
        mp_q[0] <= cmul_q(mult_a_i_o, mult_a_q_o, mult_b_i_o, mult_b_q_o);
        for (int k = 1; k < MULT_LAT; k++) begin
            mp_i[k] <= mp_i[k-1];
            mp_q[k] <= mp_q[k-1];
        end
    end
    assign mult_res_i_i = mp_i[MULT_LAT-1];
    assign mult_res_q_i = mp_q[MULT_LAT-1];

    // ---------------- stimulus state ----------------
    logic [DW-1:0] op_ai [NUM_REQ];
    logic [DW-1:0] op_aq [NUM_REQ];
    logic [DW-1:0] op_bi [NUM_REQ];
    logic [DW-1:0] op_bq [NUM_REQ];

    // ---------------- reference model ----------------
    int                 n_cmp, n_fail, cyc;
    int                 due [NUM_REQ];       // cycle the result becomes visible, -1 = none
    logic [DW-1:0]      e_ri [NUM_REQ];
    logic [DW-1:0]      e_rq [NUM_REQ];
    logic [NUM_REQ-1:0] m_busy;
    int                 m_ptr;
    int                 last_g;
    logic [DW-1:0]      e_mai, e_maq, e_mbi, e_mbq;
    logic [NUM_REQ-1:0] obs_ready, obs_rv, obs_busy;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_ops();
        for (int n = 0; n < NUM_REQ; n++) begin
            req_a_i_i[n*DW +: DW] = op_ai[n];
            req_a_q_i[n*DW +: DW] = op_aq[n];
            req_b_i_i[n*DW +: DW] = op_bi[n];
            req_b_q_i[n*DW +: DW] = op_bq[n];
        end
    endtask

    task automatic rand_ops();
        for (int n = 0; n < NUM_REQ; n++) begin
            op_ai[n] = DW'($urandom);
            op_aq[n] = DW'($urandom);
            op_bi[n] = DW'($urandom);
            op_bq[n] = DW'($urandom);
        end
        pack_ops();
    endtask

    task automatic model_reset();
        m_busy = '0;
        m_ptr  = NUM_REQ - 1;
        last_g = -1;
        e_mai = '0; e_maq = '0; e_mbi = '0; e_mbq = '0;
        for (int n = 0; n < NUM_REQ; n++) due[n] = -1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ready"},     req_ready_o,  '0);
        check({tag, "_mvalid"},    mult_valid_o, '0);
        check({tag, "_mai"},       mult_a_i_o,   '0);
        check({tag, "_maq"},       mult_a_q_o,   '0);
        check({tag, "_mbi"},       mult_b_i_o,   '0);
        check({tag, "_mbq"},       mult_b_q_o,   '0);
        check({tag, "_res_valid"}, res_valid_o,  '0);
        check({tag, "_res_i"},     res_i_o,      '0);
        check({tag, "_res_q"},     res_q_o,      '0);
        check({tag, "_busy"},      busy_o,       '0);
    endtask

    // One clock: sample and compare at the falling edge, advance the model,
    // then return just after the next rising edge so the caller can drive.
    task automatic tick();
        int                 g;
        logic [NUM_REQ-1:0] elig, exp_ready, exp_rv;
        @(negedge clk_i);
        obs_ready = req_ready_o;
        obs_rv    = res_valid_o;
        obs_busy  = busy_o;
        elig = req_valid_i & ~m_busy;
        g = -1;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int j;
            j = (m_ptr + i) % NUM_REQ;
            if (g < 0 && elig[j]) g = j;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready_o, exp_ready);
        check("busy", busy_o, m_busy);
        check("mult_valid", mult_valid_o, last_g >= 0);
        check("mult_ops", {mult_a_i_o, mult_a_q_o, mult_b_i_o, mult_b_q_o},
              {e_mai, e_maq, e_mbi, e_mbq});
        for (int n = 0; n < NUM_REQ; n++) exp_rv[n] = (due[n] >= 0) && (cyc >= due[n]);
        check("res_valid", res_valid_o, exp_rv);
        for (int n = 0; n < NUM_REQ; n++) begin
            if (exp_rv[n]) begin
                check($sformatf("res_i[%0d]", n), res_i_o[n*DW +: DW], e_ri[n]);
                check($sformatf("res_q[%0d]", n), res_q_o[n*DW +: DW], e_rq[n]);
            end
        end
        for (int n = 0; n < NUM_REQ; n++) begin
            if (exp_rv[n] && res_ready_i[n]) begin
                due[n]    = -1;
                m_busy[n] = 1'b0;
            end
        end
        last_g = g;
        if (g >= 0) begin
            m_ptr     = g;
            m_busy[g] = 1'b1;
            due[g]    = cyc + 2 + MULT_LAT;
            e_ri[g]   = cmul_i(op_ai[g], op_aq[g], op_bi[g], op_bq[g]);
            e_rq[g]   = cmul_q(op_ai[g], op_aq[g], op_bi[g], op_bq[g]);
            e_mai = op_ai[g]; e_maq = op_aq[g]; e_mbi = op_bi[g]; e_mbq = op_bq[g];
        end
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    task automatic drain(input string tag);
        req_valid_i = '0;
        res_ready_i = '1;
        for (int i = 0; i < 60 && m_busy != '0; i++) tick();
        check({tag, "_idle"}, busy_o, '0);
    endtask

    task automatic reset_pulse(input string tag);
        #2 srst_i = 1'b1;
        #1 reset_checks(tag);
        model_reset();
        repeat (2) @(posedge clk_i);
        #3 srst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int            k, count2;
        logic          found;
        logic [DW-1:0] exp_m5;
        logic [NUM_REQ-1:0] seq [$];

        n_cmp = 0; n_fail = 0; cyc = 0;
        srst_i = 1'b0; req_valid_i = '0; res_ready_i = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            op_ai[n] = '0; op_aq[n] = '0; op_bi[n] = '0; op_bq[n] = '0;
        end
        pack_ops();
        model_reset();

        // Power-on reset
        #1 srst_i = 1'b1;
        #2 reset_checks("rst0");
        repeat (2) @(posedge clk_i);
        #3 srst_i = 1'b0;
        @(posedge clk_i);
        #1;
        repeat (3) tick();

        // Single request: (3+4j)(1+2j) = -5+10j
        op_ai[0] = 18'd3; op_aq[0] = 18'd4; op_bi[0] = 18'd1; op_bq[0] = 18'd2;
        pack_ops();
        req_valid_i = 4'b0001;
        tick();
        check("s1_ready", obs_ready, 4'b0001);
        req_valid_i = '0;
        found = 1'b0; k = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            k++;
            if (obs_rv[0]) found = 1'b1;
        end
        check("s1_seen", found, 1'b1);
        check("s1_latency", k, 2 + MULT_LAT);
        exp_m5 = -18'sd5;
        check("s1_res_i", res_i_o[0 +: DW], exp_m5);
        check("s1_res_q", res_q_o[0 +: DW], 18'd10);
        tick();
        check("s1_hold_valid", obs_rv[0], 1'b1);
        res_ready_i = 4'b0001;
        tick();
        check("s1_busy_at_consume", obs_busy[0], 1'b1);
        res_ready_i = '0;
        tick();
        check("s1_busy_cleared", obs_busy[0], 1'b0);

        // All requesters valid, immediate consume
        res_ready_i = '1;
        req_valid_i = '1;
        for (int i = 0; i < 40; i++) begin
            rand_ops();
            tick();
        end
        drain("s2");

        // Back-pressure on requester 2
        res_ready_i = 4'b1011;
        req_valid_i = '1;
        count2 = 0;
        for (int i = 0; i < 20; i++) begin
            rand_ops();
            tick();
            if (obs_ready[2]) count2++;
        end
        check("s3_req2_issues", count2, 1);
        check("s3_req2_pending", obs_rv[2], 1'b1);
        drain("s3");

        // Wrap and skip: park the pointer on 3, then only 1 and 3 request
        req_valid_i = 4'b1000;
        rand_ops();
        tick();
        check("s4_park", obs_ready, 4'b1000);
        drain("s4a");
        req_valid_i = 4'b1010;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            tick();
            if (obs_ready != '0) seq.push_back(obs_ready);
        end
        check("s4_count", seq.size() >= 3, 1'b1);
        if (seq.size() >= 3) begin
            check("s4_g0", seq[0], 4'b0010);
            check("s4_g1", seq[1], 4'b1000);
            check("s4_g2", seq[2], 4'b0010);
        end
        drain("s4b");

        // Reset two cycles after an issue
        req_valid_i = 4'b0001;
        rand_ops();
        tick();
        check("s5_issue", obs_ready, 4'b0001);
        req_valid_i = '0;
        tick();
        tick();
        reset_pulse("s5_rst");
        repeat (6) tick();
        check("s5_no_stale", obs_rv, '0);
        req_valid_i = '1;
        res_ready_i = '1;
        rand_ops();
        tick();
        check("s5_first_grant", obs_ready, 4'b0001);
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            tick();
        end
        drain("s5");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            req_valid_i = NUM_REQ'($urandom);
            res_ready_i = NUM_REQ'($urandom);
            rand_ops();
            tick();
        end
        drain("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
